sync_fifo_v2: RTL and testbench

Second-generation parameterised synchronous FIFO for single-clock datapath buffering. It extends the existing 8x8 FIFO with several features:
- programmable almost-full and almost-empty thresholds;
- a fill-count output;
- a first-word-fall-through (FWFT) read mode;
- a synchronous flush;
- sticky overflow and underflow error flags.

It drops in wherever the current FIFO is instantiated, between a producer and a consumer in the same clock domain.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_ram.sv | 25 ++
 rtl/sync_fifo_v2.sv | 119 +++++++++++
 tb/tb_sync_fifo_v2.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: width helpers, defaults
// and the per-cycle operation encoding used by the occupancy counter.
package fifo_pkg;

   localparam int DEF_DATA_W   = 8;
   localparam int DEF_DEPTH    = 8;
   localparam int DEF_AE_LEVEL = 2;
   localparam int DEF_FWFT     = 0;

   typedef enum logic [1:0] {
      OP_IDLE  = 2'b00,
      OP_READ  = 2'b01,
      OP_WRITE = 2'b10,
      OP_BOTH  = 2'b11
   } fifo_op_e;

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read
// port. Contents are never reset.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [ptr_w(DEPTH)-1:0]   waddr,
   input  logic [DATA_W-1:0]         wdata,
   input  logic [ptr_w(DEPTH)-1:0]   raddr,
   output logic [DATA_W-1:0]         rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO with programmable almost-full/empty thresholds, fill count,
// sticky error flags, synchronous flush and optional first-word-fall-through.
module sync_fifo_v2
   import fifo_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = DEF_AE_LEVEL,
   parameter int FWFT     = DEF_FWFT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        din,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        dout,
   output logic                     valid,
   output logic [cnt_w(DEPTH)-1:0]  count,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int CW = cnt_w(DEPTH);
   localparam int PW = ptr_w(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo_v2: DEPTH must be a power of two >= 2");
   end
   if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_levels
      $error("sync_fifo_v2: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
   end

   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_acc, wr_acc;
   fifo_op_e          op;

   // A read at full frees a slot in the same edge, so the write may proceed.
   assign rd_acc = rd_en && !empty;
   assign wr_acc = wr_en && (!full || rd_acc);
   assign op     = fifo_op_e'({wr_acc, rd_acc});

   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);

   fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc && rst && !clr),
      .waddr (wr_ptr),
      .wdata (din),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clr) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         case (op)
            OP_WRITE: count <= count + 1'b1;
            OP_READ:  count <= count - 1'b1;
            default:  count <= count;
         endcase
         overflow  <= overflow  | (wr_en && !wr_acc);
         underflow <= underflow | (rd_en && empty);
      end
   end

   // Output stage: registered pop (standard) or live head word (fall-through).
   if (FWFT == 0) begin : g_std
      logic [DATA_W-1:0] dout_p1;
      logic              vld_p1;

      always_ff @(posedge clk) begin
         if (!rst) begin
            dout_p1 <= '0;
            vld_p1  <= 1'b0;
         end else if (clr) begin
            vld_p1  <= 1'b0;
         end else begin
            vld_p1 <= rd_acc;
            if (rd_acc) dout_p1 <= rd_data;
         end
      end

      assign dout  = dout_p1;
      assign valid = vld_p1;
   end else begin : g_fwft
      assign dout  = rd_data;
      assign valid = !empty;
   end

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Drives one stimulus stream into a standard-mode and a fall-through FIFO and
// compares both against a queue-based reference.
module tb_sync_fifo_v2;

   localparam int DW    = 8;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          clr = 1'b0;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic [DW-1:0] din = '0;

   logic [DW-1:0] s_dout, f_dout;
   logic          s_valid, f_valid;
   logic [3:0]    s_count, f_count;
   logic          s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
   logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf;

   sync_fifo_v2 #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_std (
      .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
      .dout(s_dout), .valid(s_valid), .count(s_count), .full(s_full), .empty(s_empty),
      .almost_full(s_af), .almost_empty(s_ae), .overflow(s_ovf), .underflow(s_udf));

   sync_fifo_v2 #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_fw (
      .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
      .dout(f_dout), .valid(f_valid), .count(f_count), .full(f_full), .empty(f_empty),
      .almost_full(f_af), .almost_empty(f_ae), .overflow(f_ovf), .underflow(f_udf));

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference state
   logic [DW-1:0] q[$];
   bit            m_ovf = 0, m_udf = 0, m_vld = 0;
   logic [DW-1:0] m_dout = '0;

   bit        seen_cnt[9];
   bit        rose[6], fell[6];
   logic [5:0] prev_flags = 6'b000000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit rd_ok, wr_ok;
      if (!rst || clr) begin
         q.delete();
         m_ovf = 0;
         m_udf = 0;
         m_vld = 0;
         if (!rst) m_dout = '0;
      end else begin
         rd_ok = rd_en && (q.size() > 0);
         wr_ok = wr_en && ((q.size() < DEPTH) || rd_ok);
         if (wr_en && !wr_ok) m_ovf = 1;
         if (rd_en && q.size() == 0) m_udf = 1;
         m_vld = rd_ok;
         if (rd_ok) m_dout = q.pop_front();
         if (wr_ok) q.push_back(din);
      end
   endtask

   task automatic check_all();
      int n;
      logic [5:0] fl;
      n = q.size();
      chk("std_count", s_count, n);
      chk("fw_count", f_count, n);
      chk("std_full", s_full, n == DEPTH);
      chk("std_empty", s_empty, n == 0);
      chk("std_afull", s_af, n >= 6);
      chk("std_aempty", s_ae, n <= 2);
      chk("fw_full", f_full, n == DEPTH);
      chk("fw_empty", f_empty, n == 0);
      chk("std_ovf", s_ovf, m_ovf);
      chk("std_udf", s_udf, m_udf);
      chk("fw_ovf", f_ovf, m_ovf);
      chk("fw_udf", f_udf, m_udf);
      chk("std_valid", s_valid, m_vld);
      chk("std_dout", s_dout, m_dout);
      chk("fw_valid", f_valid, n > 0);
      if (n > 0) chk("fw_dout", f_dout, q[0]);
      if (s_count <= 4'd8) seen_cnt[s_count] = 1;
      fl = {s_full, s_empty, s_af, s_ae, s_ovf, s_udf};
      for (int k = 0; k < 6; k++) begin
         if (fl[k] && !prev_flags[k]) rose[k] = 1;
         if (!fl[k] && prev_flags[k]) fell[k] = 1;
      end
      prev_flags = fl;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic drive(input bit w, input bit r, input logic [DW-1:0] d);
      wr_en = w;
      rd_en = r;
      din   = d;
   endtask

   task automatic fill_seq();
      for (int i = 1; i <= DEPTH; i++) begin
         drive(1, 0, DW'(i));
         step();
      end
      drive(0, 0, '0);
   endtask

   initial begin
      int wp, rp;
      bit all_cnt, all_tog;

      // Reset
      rst = 1'b0;
      step();
      step();
      chk("rst_count", s_count, 0);
      chk("rst_empty", s_empty, 1);
      chk("rst_aempty", s_ae, 1);
      chk("rst_full", s_full, 0);
      chk("rst_afull", s_af, 0);
      chk("rst_valid", s_valid, 0);
      chk("rst_dout", s_dout, 0);
      rst = 1'b1;

      // Fill with threshold checks, then overflow
      for (int i = 1; i <= DEPTH; i++) begin
         drive(1, 0, DW'(i));
         step();
         chk("fill_count", s_count, i);
         chk("fill_aempty", s_ae, i <= 2);
         chk("fill_afull", s_af, i >= 6);
         chk("fill_full", s_full, i == DEPTH);
      end
      drive(1, 0, 8'h99);
      step();
      chk("ovf_set", s_ovf, 1);
      chk("ovf_count", s_count, 8);

      // Drain in order, single-cycle valid per read
      for (int i = 1; i <= DEPTH; i++) begin
         drive(0, 1, '0);
         step();
         chk("drain_dout", s_dout, i);
         chk("drain_valid", s_valid, 1);
         drive(0, 0, '0);
         step();
         chk("drain_valid_off", s_valid, 0);
      end
      chk("drain_empty", s_empty, 1);
      drive(0, 1, '0);
      step();
      chk("udf_set", s_udf, 1);
      chk("udf_count", s_count, 0);

      // Simultaneous read/write at full
      rst = 1'b0;
      drive(0, 0, '0);
      step();
      rst = 1'b1;
      fill_seq();
      drive(1, 1, 8'hAA);
      step();
      chk("rw_full_count", s_count, 8);
      chk("rw_full_dout", s_dout, 8'h01);
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 1, '0);
         step();
      end
      chk("rw_last_word", s_dout, 8'hAA);
      chk("rw_empty", s_empty, 1);

      // Fall-through: one write shows up on dout without a read
      rst = 1'b0;
      drive(0, 0, '0);
      step();
      rst = 1'b1;
      drive(1, 0, 8'h5C);
      step();
      drive(0, 0, '0);
      chk("fwft_valid", f_valid, 1);
      chk("fwft_dout", f_dout, 8'h5C);
      drive(0, 1, '0);
      step();
      chk("fwft_pop_valid", f_valid, 0);
      chk("fwft_pop_empty", f_empty, 1);

      // Flush with a concurrent write
      drive(0, 0, '0);
      step();
      fill_seq();
      drive(1, 0, 8'h77);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, '0);
         step();
      end
      chk("pre_clr_count", s_count, 5);
      chk("pre_clr_ovf", s_ovf, 1);
      clr = 1'b1;
      drive(1, 0, 8'h33);
      step();
      clr = 1'b0;
      drive(0, 0, '0);
      chk("clr_count", s_count, 0);
      chk("clr_empty", s_empty, 1);
      chk("clr_ovf", s_ovf, 0);
      step();
      chk("clr_write_dropped", s_count, 0);

      // Random traffic with alternating fill/drain bias and a mid-run reset
      for (int cyc = 0; cyc < 600; cyc++) begin
         wp = ((cyc / 40) % 2 == 0) ? 80 : 25;
         rp = ((cyc / 40) % 2 == 0) ? 25 : 80;
         wr_en = ($urandom_range(0, 99) < wp);
         rd_en = ($urandom_range(0, 99) < rp);
         din   = DW'($urandom);
         clr   = ($urandom_range(0, 199) == 0);
         rst   = (cyc != 300);
         step();
         if (cyc == 300) begin
            chk("midrst_count", s_count, 0);
            chk("midrst_empty", s_empty, 1);
            chk("midrst_valid", s_valid, 0);
            chk("midrst_dout", s_dout, 0);
            chk("midrst_ovf", s_ovf, 0);
            chk("midrst_udf", s_udf, 0);
         end
      end
      rst = 1'b1;
      clr = 1'b0;
      drive(0, 0, '0);

      all_cnt = 1;
      for (int k = 0; k <= DEPTH; k++) if (!seen_cnt[k]) all_cnt = 0;
      all_tog = 1;
      for (int k = 0; k < 6; k++) if (!rose[k] || !fell[k]) all_tog = 0;
      chk("cov_count_values", all_cnt, 1);
      chk("cov_flag_toggles", all_tog, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
